// File: rtl/input_decoder_ctrl.sv
// Command-packet parser: pops header/argument words from a first-word-fall-through FIFO
// and presents one decoded GPU command to the rasterizer over a valid/ready handshake.
module input_decoder_ctrl #(
  parameter int COORD_W   = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          fifo_r_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [1:0]           cmd_opcode,
  output logic [23:0]          cmd_color,
  output logic [COORD_W-1:0]   cmd_x0,
  output logic [COORD_W-1:0]   cmd_y0,
  output logic [COORD_W-1:0]   cmd_x1,
  output logic [COORD_W-1:0]   cmd_y1,
  output logic                 busy,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           dbg_state
);

  // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
  // cmd_valid depends only on state, and all cmd_* outputs are held stable until the transfer.
  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_ARG0  = 2'd1,
    S_ARG1  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_fifo_read;
  logic [3:0]           w_hdr_op;
  logic                 w_hdr_invalid;
  logic [COORD_W-1:0]   w_arg_x;
  logic [COORD_W-1:0]   w_arg_y;
  logic                 w_unused;

  logic [1:0]           r_opcode;
  logic [23:0]          r_color;
  logic [COORD_W-1:0]   r_x0;
  logic [COORD_W-1:0]   r_y0;
  logic [COORD_W-1:0]   r_x1;
  logic [COORD_W-1:0]   r_y1;
  logic                 r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_hdr_op      = fifo_r_data[31:28];
  assign w_hdr_invalid = (w_hdr_op[3:2] != 2'b00);
  assign w_arg_x       = fifo_r_data[COORD_W-1:0];
  assign w_arg_y       = fifo_r_data[16+COORD_W-1:16];
  assign w_unused      = ^fifo_r_data[27:24];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_fifo_read  = 1'b0;
    case (r_state)
      S_HDR: begin
        if (!fifo_empty) begin
          w_fifo_read = 1'b1;
          if (w_hdr_op == 4'd1) begin
            w_next_state = S_ISSUE;
          end else if ((w_hdr_op == 4'd2) || (w_hdr_op == 4'd3)) begin
            w_next_state = S_ARG0;
          end
        end
      end
      S_ARG0: begin
        if (!fifo_empty) begin
          w_fifo_read  = 1'b1;
          w_next_state = S_ARG1;
        end
      end
      S_ARG1: begin
        if (!fifo_empty) begin
          w_fifo_read  = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          w_next_state = S_HDR;
        end
      end
      default: w_next_state = S_HDR;
    endcase
  end

  // Reset gates the pop so the FIFO is never consumed while the parser is held in reset.
  assign fifo_read = w_fifo_read && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_opcode    <= 2'd0;
      r_color     <= 24'd0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_fifo_read) begin
        case (r_state)
          S_HDR: begin
            if (w_hdr_invalid) begin
              r_err_pulse <= 1'b1;
              if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
              end
            end else if (w_hdr_op == 4'd1) begin
              r_opcode <= 2'd1;
              r_color  <= fifo_r_data[23:0];
              r_x0     <= '0;
              r_y0     <= '0;
              r_x1     <= '0;
              r_y1     <= '0;
            end else if (w_hdr_op != 4'd0) begin
              r_opcode <= w_hdr_op[1:0];
              r_color  <= fifo_r_data[23:0];
            end
          end
          S_ARG0: begin
            r_x0 <= w_arg_x;
            r_y0 <= w_arg_y;
          end
          S_ARG1: begin
            r_x1 <= w_arg_x;
            r_y1 <= w_arg_y;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_valid  = (r_state == S_ISSUE);
  assign busy       = (r_state != S_HDR);
  assign cmd_opcode = r_opcode;
  assign cmd_color  = r_color;
  assign cmd_x0     = r_x0;
  assign cmd_y0     = r_y0;
  assign cmd_x1     = r_x1;
  assign cmd_y1     = r_y1;
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_input_decoder_ctrl.sv
// Bench for input_decoder_ctrl: FIFO and rasterizer models driven on the falling edge,
// a packet-level reference model filling an expected-command queue, directed plus random phases.
module tb_input_decoder_ctrl;

  localparam int W = 90;

  logic        clk;
  logic        reset;
  logic [31:0] fifo_r_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode;
  logic [23:0] cmd_color;
  logic [15:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic        busy;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  input_decoder_ctrl #(.COORD_W(16), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .fifo_r_data(fifo_r_data), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_color(cmd_color), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .busy(busy), .err_pulse(err_pulse), .err_count(err_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]  fifo_q[$];
  logic [31:0]  m_pkt[$];
  logic [W-1:0] exp_q[$];
  int           pop_log[$];
  int           hs_log[$];
  int           m_err = 0;
  int           pulses = 0;
  int           cyc = 0;
  logic         exp_pulse = 1'b0;
  logic         stall = 1'b0;
  logic         ready_drv = 1'b0;
  logic [W-1:0] last_cmd = '0;

  function automatic logic [W-1:0] pack(input logic [1:0] op, input logic [23:0] col,
                                        input logic [15:0] x0, input logic [15:0] y0,
                                        input logic [15:0] x1, input logic [15:0] y1);
    return {op, col, x0, y0, x1, y1};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: interprets each consumed word at packet level.
  task automatic model_word(input logic [31:0] w);
    logic [3:0] op;
    if (m_pkt.size() == 0) begin
      op = w[31:28];
      if (op == 4'd1) begin
        exp_q.push_back(pack(2'd1, w[23:0], 16'd0, 16'd0, 16'd0, 16'd0));
      end else if (op == 4'd2 || op == 4'd3) begin
        m_pkt.push_back(w);
      end else if (op >= 4'd4) begin
        if (m_err < 255) m_err++;
        exp_pulse = 1'b1;
      end
    end else begin
      m_pkt.push_back(w);
      if (m_pkt.size() == 3) begin
        exp_q.push_back(pack(m_pkt[0][29:28], m_pkt[0][23:0], m_pkt[1][15:0], m_pkt[1][31:16],
                             m_pkt[2][15:0], m_pkt[2][31:16]));
        m_pkt.delete();
      end
    end
  endtask

  // FIFO / rasterizer drivers and scoreboard, all away from the rising edge.
  always @(negedge clk) begin
    logic         exp_rd;
    logic [31:0]  w;
    logic [W-1:0] got;
    fifo_empty  = stall || (fifo_q.size() == 0);
    fifo_r_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    cmd_ready   = ready_drv;
    #1;
    cyc++;
    if (!reset) begin
      chk("rst_fifo_read", fifo_read, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_cmd_data", pack(cmd_opcode, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1), 0);
      m_pkt.delete();
      exp_q.delete();
      m_err = 0;
      exp_pulse = 1'b0;
    end else begin
      exp_rd = !fifo_empty && (exp_q.size() == 0);
      chk("fifo_read", fifo_read, exp_rd);
      chk("cmd_valid", cmd_valid, exp_q.size() != 0);
      chk("busy", busy, (exp_q.size() != 0) || (m_pkt.size() != 0));
      chk("err_pulse", err_pulse, exp_pulse);
      chk("err_count", err_count, m_err);
      if (err_pulse) pulses++;
      exp_pulse = 1'b0;
      if (cmd_valid && cmd_ready) begin
        got = pack(cmd_opcode, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1);
        if (exp_q.size() != 0) chk("cmd_data", got, exp_q.pop_front());
        last_cmd = got;
        hs_log.push_back(cyc);
      end
      if (fifo_read && !fifo_empty) begin
        w = fifo_q.pop_front();
        model_word(w);
        pop_log.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_pkt.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) begin
      n_vec++;
      n_err++;
      $error("FAIL wait_idle observed=timeout expected=drain within %0d cycles", budget);
    end
  endtask

  task automatic push_rand_packet();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) fifo_q.push_back({4'd0, 28'($urandom)});
    else if (r <= 2) fifo_q.push_back({4'd1, 4'($urandom), 24'($urandom)});
    else if (r <= 8) begin
      fifo_q.push_back({(r <= 5) ? 4'd2 : 4'd3, 4'($urandom), 24'($urandom)});
      fifo_q.push_back($urandom);
      fifo_q.push_back($urandom);
    end else fifo_q.push_back({4'($urandom_range(4, 15)), 28'($urandom)});
  endtask

  initial begin
    int n0, h0, p0;
    reset = 1'b0;
    fifo_empty = 1'b1;
    fifo_r_data = 32'h0;
    cmd_ready = 1'b0;
    tick(3);
    @(negedge clk);
    reset = 1'b1;
    #2;

    // DRAW_LINE latency and decode
    ready_drv = 1'b1;
    n0 = pop_log.size();
    h0 = hs_log.size();
    fifo_q.push_back(32'h20FF00FF);
    fifo_q.push_back(32'h0005000A);
    fifo_q.push_back(32'h0014001E);
    wait_idle(50);
    chk("t1_pop_count", pop_log.size() - n0, 3);
    chk("t1_consecutive", pop_log[n0+2] - pop_log[n0], 2);
    chk("t1_latency", hs_log[h0] - pop_log[n0], 3);
    chk("t1_cmd", last_cmd, pack(2'd2, 24'h0FF00FF, 16'd10, 16'd5, 16'd30, 16'd20));
    tick(2);

    // CLEAR held while the rasterizer stalls
    ready_drv = 1'b0;
    fifo_q.push_back(32'h10123456);
    fifo_q.push_back(32'h10000002);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t2_valid_hold", cmd_valid, 1);
      chk("t2_hold_data", pack(cmd_opcode, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1),
          pack(2'd1, 24'h123456, 16'd0, 16'd0, 16'd0, 16'd0));
      chk("t2_no_read", fifo_read, 0);
    end
    ready_drv = 1'b1;
    tick(2);
    chk("t2_next_pop", pop_log[pop_log.size()-1] - hs_log[hs_log.size()-1], 1);
    wait_idle(50);
    tick(2);

    // FILL_RECT with FIFO gaps between words
    fifo_q.push_back(32'h3000ABCD);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t3_busy_arg0", busy, 1);
      chk("t3_no_read_arg0", fifo_read, 0);
    end
    fifo_q.push_back(32'h00020001);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t3_busy_arg1", busy, 1);
      chk("t3_no_valid", cmd_valid, 0);
    end
    fifo_q.push_back(32'h00400030);
    wait_idle(50);
    chk("t3_cmd", last_cmd, pack(2'd3, 24'h00ABCD, 16'd1, 16'd2, 16'h30, 16'h40));
    tick(2);

    // NOP, invalid, CLEAR
    p0 = pulses;
    h0 = hs_log.size();
    fifo_q.push_back(32'h00000000);
    fifo_q.push_back(32'h70000000);
    fifo_q.push_back(32'h10000001);
    wait_idle(50);
    tick(2);
    chk("t4_pulses", pulses - p0, 1);
    chk("t4_err_count", err_count, 1);
    chk("t4_one_cmd", hs_log.size() - h0, 1);
    chk("t4_cmd", last_cmd, pack(2'd1, 24'h000001, 16'd0, 16'd0, 16'd0, 16'd0));

    // error counter saturation
    for (int i = 0; i < 300; i++) fifo_q.push_back({4'($urandom_range(4, 15)), 28'($urandom)});
    wait_idle(400);
    tick(2);
    chk("t5_saturated", err_count, 255);

    // reset in the middle of a DRAW_LINE
    fifo_q.push_back(32'h20000005);
    fifo_q.push_back(32'h00030004);
    for (int k = 0; k < 20 && m_pkt.size() != 2; k++) tick(1);
    chk("t6_partial", m_pkt.size(), 2);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("t6_rst_valid", cmd_valid, 0);
    chk("t6_rst_err", err_count, 0);
    chk("t6_rst_busy", busy, 0);
    fifo_q.delete();
    tick(2);
    @(negedge clk);
    reset = 1'b1;
    #2;
    fifo_q.push_back(32'h10ABCDEF);
    wait_idle(50);
    chk("t6_cmd", last_cmd, pack(2'd1, 24'hABCDEF, 16'd0, 16'd0, 16'd0, 16'd0));

    // randomized traffic with stalls and backpressure
    for (int i = 0; i < 800; i++) begin
      if (fifo_q.size() < 4) push_rand_packet();
      stall = ($urandom_range(0, 3) == 0);
      ready_drv = ($urandom_range(0, 9) < 7);
      tick(1);
    end
    stall = 1'b0;
    ready_drv = 1'b1;
    wait_idle(200);
    tick(2);
    chk("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
